// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CSUM,
    S_DONE
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 8-to-32 shift register; o_full flags the shift that completes a word.
module byte_packer
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_shift_en,
  input  logic        i_clr,
  input  logic [7:0]  i_byte_in,
  output logic [31:0] o_word_out,
  output logic        o_full
);

  logic [BIDX_W-1:0] r_cnt;
  logic [31:0]       r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_shift_en) begin
      r_word <= {r_word[23:0], i_byte_in};
      r_cnt  <= r_cnt + BIDX_W'(1);
    end
  end

  // Combinational so the FSM can leave RECV on the same edge the fourth byte lands.
  assign o_full     = i_shift_en && (r_cnt == BIDX_W'(BYTES_PER_WORD - 1));
  assign o_word_out = r_word;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory writer; holds the CPU while loading.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_word_count,
  input  logic             i_in_valid,
  input  logic [7:0]       i_in_data,
  output logic             o_in_ready,
  output logic             o_mem_we,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic             o_cpu_hold,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_word_idx;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      w_word;
  logic             w_full;
  logic             w_start_acc;
  logic             w_shift_en;
  logic             w_last;
  logic             w_in_ready;

  assign w_start_acc = (r_state == S_IDLE) && i_start;
  assign w_shift_en  = (r_state == S_RECV) && i_in_valid;
  assign w_last      = (r_word_idx + CNT_W'(1)) == r_count;
  assign w_in_ready  = (r_state == S_RECV) || (r_state == S_CSUM);

  byte_packer u_packer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_shift_en (w_shift_en),
    .i_clr      (w_start_acc),
    .i_byte_in  (i_in_data),
    .o_word_out (w_word),
    .o_full     (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = (i_word_count == '0) ? S_DONE : S_RECV;
      S_RECV:  if (w_full) w_state_nxt = S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_WRITE: w_state_nxt = w_last ? S_CSUM : S_RECV;
      S_CSUM:  if (i_in_valid) w_state_nxt = S_DONE;
`else
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_RECV;
`endif
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_addr     <= BASE_ADDR;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_count    <= i_word_count;
        r_word_idx <= '0;
      end
      // Address is staged as the word completes so it is ready during WRITE.
      if (w_full)
        r_addr <= BASE_ADDR + (32'(r_word_idx) << 2);
      if (r_state == S_WRITE) begin
        r_wdata    <= w_word;
        r_word_idx <= r_word_idx + CNT_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic       r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (w_shift_en) begin
      r_sum <= r_sum + i_in_data;
    end else if ((r_state == S_CSUM) && i_in_valid) begin
      r_err <= (r_sum + i_in_data) != 8'h00;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  // The packer keeps shifting after a write, so the data port shows the live
  // word only during WRITE and the captured copy everywhere else.
  assign o_mem_wdata = (r_state == S_WRITE) ? w_word : r_wdata;
  assign o_mem_addr  = r_addr;
  assign o_in_ready  = w_in_ready;
  assign o_mem_we    = (r_state == S_WRITE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_cpu_hold  = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface that the single-cycle CPU reads from.
- Receives a byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words, and writes them to consecutive word addresses through the instruction memory's write port.
- Holds the CPU (drives cpu_hold) while a program is being loaded, so the PC does not fetch a partially written image.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
CNT_W, 16, width of word_count and of the internal word index.

Ports:
clk  in  1  system clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle load request; sampled only in IDLE.
word_count  in  CNT_W  number of 32-bit words to load; latched when start is accepted.
in_valid  in  1  in_data is valid this cycle.
in_data  in  8  payload byte.
in_ready  out  1  loader can accept a byte this cycle.
mem_we  out  1  instruction memory write strobe, one cycle per word.
mem_addr  out  32  byte address of the word being written.
mem_wdata  out  32  packed instruction word.
cpu_hold  out  1  stall request to the CPU; PCWre must be forced low while this is high.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the load completes.
err  out  1  checksum error flag; only meaningful with CHECKSUM_EN.

Behaviour:
- Reset (Reset=0, any state, asynchronous): state=IDLE; in_ready, mem_we, cpu_hold, busy, done and err are 0; mem_addr=BASE_ADDR; mem_wdata=0; byte index and word index are 0. A partially received word is discarded and no write is issued.
- States: IDLE, RECV, WRITE, [CSUM], DONE.
- IDLE:
  - On start=1, latch word_count and clear the indices and err.
  - If word_count==0, go to DONE; otherwise go to RECV.
  - start is ignored in every other state.
- RECV:
  - in_ready=1.
  - A byte transfers when in_valid && in_ready.
  - Byte order is big-endian: the first byte goes to [31:24], the fourth byte to [7:0].
  - in_valid gaps are allowed; the state holds until four bytes have transferred, then goes to WRITE on the next edge.
- WRITE:
  - in_ready=0; mem_we=1 for exactly one cycle.
  - mem_addr = BASE_ADDR + 4*word_idx, computed modulo 2^32 (wraps silently).
  - mem_wdata is the packed word.
  - Then word_idx is incremented. If word_idx+1 == word_count, go to CSUM when checksum is enabled, otherwise DONE; if not the last word, go to RECV.
- DONE: done=1 for one cycle, then IDLE.
- Latency and throughput:
  - mem_we asserts on the cycle after the fourth byte is accepted.
  - Best-case throughput is 5 cycles per word (4 RECV + 1 WRITE).
- cpu_hold and busy:
  - Both rise on the cycle after start is accepted.
  - Both fall when the state returns to IDLE; they remain high during the DONE cycle.
- Outputs are registered. mem_addr and mem_wdata hold their last values outside WRITE.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the loader enters CSUM with in_ready=1 and accepts exactly one byte.
  - err = ((sum of all payload bytes + checksum byte) mod 256) != 0.
  - err is set on the DONE cycle and held until the next accepted start or reset.
  - For word_count==0, CSUM is skipped and err=0.
- Undefined: the CSUM state does not exist and err is tied to 0.

Decomposition:
- Shared package loader_pkg: state enum (IDLE, RECV, WRITE, CSUM, DONE), BYTES_PER_WORD=4, the 2-bit byte-index width.
- One sub-module, byte_packer:
  - 8-to-32 shift register with a byte counter.
  - Inputs: clk, Reset, shift_en, clr, byte_in.
  - Outputs: word_out, full.
- The FSM, address generation and checksum accumulator stay in imem_loader.

Test Plan:
- Basic load: start with word_count=2, BASE_ADDR=0, stream 12 34 56 78 DE AD BE EF back-to-back -> mem_we at addr 0x0 with data 0x12345678, mem_we at addr 0x4 with data 0xDEADBEEF; done pulses once; cpu_hold high throughout the load and low afterwards.
- Handshake gaps: same stream with in_valid low for 3 cycles between every byte -> identical writes, in_ready stays 1 through the gaps, no extra mem_we.
- Empty load: start with word_count=0 -> done one cycle after IDLE exit, no mem_we, cpu_hold high for exactly 1 cycle.
- Reset mid-word: after 2 bytes are accepted, pulse Reset low -> all outputs 0 asynchronously, no write issued; a new load of 1 word writes correctly at BASE_ADDR.
- Start while busy: assert start mid-RECV with word_count=9 -> ignored; the original count completes and exactly the original number of mem_we strobes occurs.
- Checksum (IMEM_LOADER_CHECKSUM_EN defined): word 01 02 03 04 followed by checksum byte F6 -> err=0; the same word with checksum byte 00 -> err=1, held until the next start.
